ceespu_execute: RTL and testbench

CEESPU_EXECUTE -- requirements
Module: ceespu_execute

---
 rtl/ceespu_execute_if.sv | 49 ++++
 rtl/ceespu_execute.sv | 231 +++++++++++++++++++++++
 tb/tb_ceespu_execute.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ceespu_execute_if.sv
// ceespu_execute_if
//   Groups the ID/EX instruction inputs, the pipeline control inputs and the
//   EX/MEM register outputs of the ceespu execute stage.
//
//   Handshake: I_valid marks an instruction on the ID/EX inputs. It is consumed
//   at a rising edge where I_valid=1, O_stall=0 and I_flush=0. While O_stall=1
//   the producer must hold every ID/EX field steady. I_memStall is the
//   downstream "cannot accept" signal. While it is high, the EX/MEM register
//   (O_valid/O_result/O_rd/O_we) and O_carry keep their values. O_valid
//   therefore stays high across stalled edges for one and the same result.
//
//   modport master : instruction producer / pipeline controller side
//   modport slave  : the execute stage
interface ceespu_execute_if;
  // ID/EX inputs
  logic        I_valid;
  logic [3:0]  I_aluop;
  logic [31:0] I_srcA;
  logic [31:0] I_srcB;
  logic [1:0]  I_fwdA;
  logic [1:0]  I_fwdB;
  logic [31:0] I_wbData;
  logic [4:0]  I_rd;
  logic        I_we;
  logic        I_useC;
  logic        I_setC;
  // pipeline control
  logic        I_memStall;
  logic        I_flush;
  // stage outputs
  logic        O_stall;
  logic        O_valid;
  logic [31:0] O_result;
  logic [4:0]  O_rd;
  logic        O_we;
  logic        O_carry;

  modport master (
    output I_valid, I_aluop, I_srcA, I_srcB, I_fwdA, I_fwdB, I_wbData,
    output I_rd, I_we, I_useC, I_setC, I_memStall, I_flush,
    input  O_stall, O_valid, O_result, O_rd, O_we, O_carry
  );

  modport slave (
    input  I_valid, I_aluop, I_srcA, I_srcB, I_fwdA, I_fwdB, I_wbData,
    input  I_rd, I_we, I_useC, I_setC, I_memStall, I_flush,
    output O_stall, O_valid, O_result, O_rd, O_we, O_carry
  );
endinterface

// File: rtl/ceespu_execute.sv
// ceespu_execute
//   Execute stage of the ceespu pipeline. It resolves operand forwarding, drives
//   an external ALU, and owns the EX/MEM register and the carry flag. It also
//   sequences multi-cycle ALU operations (multiply). While such an operation
//   runs, the stage stalls upstream.
//
//   Ports:
//     I_clk, I_rst      clock, synchronous active-high reset
//     bus (slave)       ID/EX inputs, I_memStall/I_flush, O_stall and EX/MEM outputs
//     O_aluA/O_aluB     ALU operands
//     O_aluop           ALU operation (0 when idle, so the ALU sees a no-op)
//     O_aluCin          ALU carry-in
//     I_aluResult/I_aluCout  ALU result and carry-out
//     I_aluMulti        the operation on O_aluop is multi-cycle
//     I_aluReady        the multi-cycle result is valid this cycle
//     O_state           current FSM state (0=RUN, 1=MUL, 2=HOLD) for debug
//
//   States:
//     RUN  : ALU is fed straight from the forwarding muxes
//     MUL  : multi-cycle op in flight, ALU fed from the hold registers
//     HOLD : result is ready but downstream is stalled. The result waits in
//            r_buf and O_aluop=0, which keeps the ALU from starting again.
module ceespu_execute #(
  parameter logic [1:0] FWD_NONE  = 2'd0,
  parameter logic [1:0] FWD_EXMEM = 2'd1,
  parameter logic [1:0] FWD_WB    = 2'd2
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  ceespu_execute_if.slave        bus,
  output logic [31:0]            O_aluA,
  output logic [31:0]            O_aluB,
  output logic [3:0]             O_aluop,
  output logic                   O_aluCin,
  input  logic [31:0]            I_aluResult,
  input  logic                   I_aluCout,
  input  logic                   I_aluMulti,
  input  logic                   I_aluReady,
  output logic [1:0]             O_state
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // EX/MEM register and carry flag
  logic        r_valid;
  logic [31:0] r_result;
  logic [4:0]  r_rd;
  logic        r_we;
  logic        r_carry;

  // Hold registers: a snapshot of what was sent to the ALU at accept time.
  // Multi-cycle operations never write the carry flag, so setC does not need
  // to outlive the accept cycle and is taken directly from the ID/EX input.
  logic [31:0] r_hA;
  logic [31:0] r_hB;
  logic [3:0]  r_hOp;
  logic        r_hCin;
  logic [4:0]  r_hRd;
  logic        r_hWe;

  // A multi-cycle result that arrived while downstream was stalled
  logic [31:0] r_buf;

  logic [31:0] w_fwdA;
  logic [31:0] w_fwdB;
  logic        w_accept;

  // Selects 3 falls through to the register-file operand as well.
  function automatic logic [31:0] f_fwd(input logic [1:0]  sel,
                                        input logic [31:0] src,
                                        input logic [31:0] exmem,
                                        input logic [31:0] wb);
    logic [31:0] v;
    case (sel)
      FWD_NONE:  v = src;
      FWD_EXMEM: v = exmem;
      FWD_WB:    v = wb;
      default:   v = src;
    endcase
    return v;
  endfunction

  always_comb begin
    w_fwdA = f_fwd(bus.I_fwdA, bus.I_srcA, r_result, bus.I_wbData);
    w_fwdB = f_fwd(bus.I_fwdB, bus.I_srcB, r_result, bus.I_wbData);
  end

  // A flush kills the cycle's instruction, so flush also blocks the accept.
  assign w_accept = (r_state == S_RUN) && bus.I_valid && !bus.I_memStall && !bus.I_flush;

  // FSM: next state and ALU-facing outputs
  always_comb begin
    w_state_next = r_state;
    O_aluA       = r_hA;
    O_aluB       = r_hB;
    O_aluop      = 4'd0;
    O_aluCin     = r_hCin;

    case (r_state)
      S_RUN: begin
        O_aluA   = w_fwdA;
        O_aluB   = w_fwdB;
        O_aluop  = bus.I_valid ? bus.I_aluop : 4'd0;
        O_aluCin = bus.I_useC & r_carry;
        if (w_accept && I_aluMulti) begin
          w_state_next = S_MUL;
        end
      end
      S_MUL: begin
        O_aluop = r_hOp;
        if (I_aluReady) begin
          w_state_next = bus.I_memStall ? S_HOLD : S_RUN;
        end
      end
      S_HOLD: begin
        // O_aluop stays 0. The ALU must not count again while the result waits.
        if (!bus.I_memStall) begin
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase

    if (bus.I_flush) begin
      O_aluop      = 4'd0;
      w_state_next = S_RUN;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers. Priority: reset, then flush, then memStall, then normal.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_valid  <= 1'b0;
      r_result <= 32'd0;
      r_rd     <= 5'd0;
      r_we     <= 1'b0;
      r_carry  <= 1'b0;
      r_hA     <= 32'd0;
      r_hB     <= 32'd0;
      r_hOp    <= 4'd0;
      r_hCin   <= 1'b0;
      r_hRd    <= 5'd0;
      r_hWe    <= 1'b0;
      r_buf    <= 32'd0;
    end else if (bus.I_flush) begin
      // Carry and the rest of the EX/MEM payload are left alone.
      r_valid <= 1'b0;
      r_hA    <= 32'd0;
      r_hB    <= 32'd0;
      r_hOp   <= 4'd0;
      r_hCin  <= 1'b0;
      r_hRd   <= 5'd0;
      r_hWe   <= 1'b0;
      r_buf   <= 32'd0;
    end else if (bus.I_memStall) begin
      // EX/MEM and carry are frozen. A result that arrives now is parked in r_buf.
      if (r_state == S_MUL && I_aluReady) begin
        r_buf <= I_aluResult;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (bus.I_valid) begin
            r_hA   <= w_fwdA;
            r_hB   <= w_fwdB;
            r_hOp  <= bus.I_aluop;
            r_hCin <= bus.I_useC & r_carry;
            r_hRd  <= bus.I_rd;
            r_hWe  <= bus.I_we;
            if (I_aluMulti) begin
              r_valid <= 1'b0;
            end else begin
              r_valid  <= 1'b1;
              r_result <= I_aluResult;
              r_rd     <= bus.I_rd;
              r_we     <= bus.I_we;
              if (bus.I_setC) begin
                r_carry <= I_aluCout;
              end
            end
          end else begin
            r_valid <= 1'b0;
          end
        end
        S_MUL: begin
          if (I_aluReady) begin
            r_valid  <= 1'b1;
            r_result <= I_aluResult;
            r_rd     <= r_hRd;
            r_we     <= r_hWe;
          end
        end
        S_HOLD: begin
          r_valid  <= 1'b1;
          r_result <= r_buf;
          r_rd     <= r_hRd;
          r_we     <= r_hWe;
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.O_stall  = (r_state != S_RUN) || bus.I_memStall;
  assign bus.O_valid  = r_valid;
  assign bus.O_result = r_result;
  assign bus.O_rd     = r_rd;
  assign bus.O_we     = r_we;
  assign bus.O_carry  = r_carry;
  assign O_state      = r_state;

endmodule

// File: tb/tb_ceespu_execute.sv
// tb_ceespu_execute
//   Directed bench for ceespu_execute. It contains a small ALU model with
//   ADD/OR/XOR and a multiply that is ready on its 3rd cycle. It also keeps a
//   scoreboard. The scoreboard holds the expected {carry, we, rd, result}
//   of each completing instruction. Each entry is worked out from the
//   operands after forwarding is resolved, using plain arithmetic.
module tb_ceespu_execute;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ceespu_execute_if bus();

  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;
  logic        alu_cin, alu_cout, alu_multi, alu_ready;
  logic [1:0]  state;
  logic [1:0]  mcnt;

  ceespu_execute dut (
    .I_clk       (clk),
    .I_rst       (rst),
    .bus         (bus),
    .O_aluA      (alu_a),
    .O_aluB      (alu_b),
    .O_aluop     (alu_op),
    .O_aluCin    (alu_cin),
    .I_aluResult (alu_res),
    .I_aluCout   (alu_cout),
    .I_aluMulti  (alu_multi),
    .I_aluReady  (alu_ready),
    .O_state     (state)
  );

  // ALU model
  always_comb begin
    alu_res  = 32'd0;
    alu_cout = 1'b0;
    case (alu_op)
      4'd0:    {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
      4'd1:    alu_res = alu_a | alu_b;
      4'd3:    alu_res = alu_a ^ alu_b;
      4'd9:    alu_res = alu_a * alu_b;
      default: alu_res = 32'd0;
    endcase
  end
  assign alu_multi = (alu_op == 4'd9);
  assign alu_ready = alu_multi && (mcnt == 2'd2);

  always @(posedge clk) begin
    if (rst)            mcnt <= 2'd0;
    else if (alu_multi) mcnt <= alu_ready ? 2'd0 : mcnt + 2'd1;
    else                mcnt <= 2'd0;
  end

  // Scoreboard and model state
  logic [38:0] exp_q[$];
  logic [38:0] e;
  logic [31:0] m_last;
  logic        m_carry;
  logic        held;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [32:0] model_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
    logic [63:0] s;
    case (op)
      4'd0: begin s = 64'(a) + 64'(b) + 64'(cin); return s[32:0]; end
      4'd1: return {1'b0, a | b};
      4'd3: return {1'b0, a ^ b};
      4'd9: begin s = 64'(a) * 64'(b); return {1'b0, s[31:0]}; end
      default: return 33'd0;
    endcase
  endfunction

  // The EX/MEM register repeats its value across a stalled edge. Only a fresh
  // load is scored.
  always @(posedge clk) held <= rst ? 1'b0 : (bus.I_memStall & ~bus.I_flush);

  always @(negedge clk) begin
    if (!rst && bus.O_valid && !held) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got result %0h, expected no output", bus.O_result);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", bus.O_result, e[31:0]);
        chk("sb_rd", 32'(bus.O_rd), 32'(e[36:32]));
        chk("sb_we", 32'(bus.O_we), 32'(e[37]));
        chk("sb_carry", 32'(bus.O_carry), 32'(e[38]));
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.I_valid = 1'b0; bus.I_aluop = 4'd0;
    bus.I_fwdA  = 2'd0; bus.I_fwdB  = 2'd0;
    bus.I_useC  = 1'b0; bus.I_setC  = 1'b0;
    bus.I_rd    = 5'd0; bus.I_we    = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] wb, input logic [1:0] fa, input logic [1:0] fb,
                       input logic usec, input logic setc, input logic [4:0] rd,
                       input logic we, input bit push);
    logic [31:0] ea, eb;
    logic        cin;
    logic [32:0] r;
    bus.I_valid = 1'b1; bus.I_aluop = op;
    bus.I_srcA = a; bus.I_srcB = b; bus.I_wbData = wb;
    bus.I_fwdA = fa; bus.I_fwdB = fb;
    bus.I_useC = usec; bus.I_setC = setc; bus.I_rd = rd; bus.I_we = we;
    ea  = (fa == 2'd1) ? m_last : (fa == 2'd2) ? wb : a;
    eb  = (fb == 2'd1) ? m_last : (fb == 2'd2) ? wb : b;
    cin = usec & m_carry;
    r   = model_op(op, ea, eb, cin);
    #1;
    chk("drv_aluA", alu_a, ea);
    chk("drv_aluB", alu_b, eb);
    chk("drv_aluop", 32'(alu_op), 32'(op));
    chk("drv_aluCin", 32'(alu_cin), 32'(cin));
    if (push) begin
      if (op != 4'd9 && setc) m_carry = r[32];
      m_last = r[31:0];
      exp_q.push_back({m_carry, we, rd, r[31:0]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.I_memStall = 1'b0; bus.I_flush = 1'b0;
    bus.I_srcA = 32'd0; bus.I_srcB = 32'd0; bus.I_wbData = 32'd0;
    idle();
    m_last = 32'd0; m_carry = 1'b0;
    step(); step();

    // reset state
    chk("rst_valid", 32'(bus.O_valid), 32'd0);
    chk("rst_result", bus.O_result, 32'd0);
    chk("rst_rd", 32'(bus.O_rd), 32'd0);
    chk("rst_we", 32'(bus.O_we), 32'd0);
    chk("rst_carry", 32'(bus.O_carry), 32'd0);
    chk("rst_stall", 32'(bus.O_stall), 32'd0);
    chk("rst_aluop", 32'(alu_op), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    rst = 1'b0;

    // ADD FFFFFFFF + 1 with setC
    drive(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1);
    chk("add_stall_accept", 32'(bus.O_stall), 32'd0);
    step(); idle();
    chk("add_result", bus.O_result, 32'd0);
    chk("add_carry", 32'(bus.O_carry), 32'd1);
    chk("add_valid", 32'(bus.O_valid), 32'd1);
    chk("add_stall", 32'(bus.O_stall), 32'd0);

    // dependent ADD then OR forwarded from EX/MEM
    drive(4'd0, 32'd5, 32'd3, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1);
    step();
    chk("dep_first", bus.O_result, 32'd8);
    drive(4'd1, 32'hDEAD_0000, 32'h10, 32'd0, 2'd1, 2'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
    chk("dep_fwd_operand", alu_a, 32'd8);
    step(); idle();
    chk("dep_second", bus.O_result, 32'h18);

    // MUL 7*6, operands must ignore changing forwarding sources
    drive(4'd9, 32'd7, 32'd6, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1);
    step(); idle();
    n = 0;
    while (bus.O_stall && n < 10) begin
      bus.I_fwdA   = n[0] ? 2'd2 : 2'd1;
      bus.I_wbData = 32'h1111_1111 * (n + 1);
      bus.I_srcA   = 32'hA5A5_0000 + n;
      #1;
      chk("mul_aluA_stable", alu_a, 32'd7);
      chk("mul_aluB_stable", alu_b, 32'd6);
      chk("mul_aluop", 32'(alu_op), 32'd9);
      n++;
      step();
    end
    bus.I_fwdA = 2'd0;
    chk("mul_stall_cycles", 32'(n), 32'd2);
    chk("mul_result", bus.O_result, 32'd42);
    chk("mul_valid", 32'(bus.O_valid), 32'd1);
    chk("mul_carry_kept", 32'(bus.O_carry), 32'd1);

    // MUL with memStall over the ready cycle
    drive(4'd9, 32'd7, 32'd6, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    step(); idle();
    bus.I_memStall = 1'b1;
    step(); step();
    chk("hold_state", 32'(state), 32'd2);
    chk("hold_aluop", 32'(alu_op), 32'd0);
    chk("hold_stall", 32'(bus.O_stall), 32'd1);
    chk("hold_valid", 32'(bus.O_valid), 32'd0);
    step(); step();
    chk("hold_state_later", 32'(state), 32'd2);
    chk("hold_valid_later", 32'(bus.O_valid), 32'd0);
    bus.I_memStall = 1'b0;
    #1;
    chk("hold_stall_release", 32'(bus.O_stall), 32'd1);
    step();
    chk("hold_result", bus.O_result, 32'd42);
    chk("hold_valid_out", 32'(bus.O_valid), 32'd1);
    chk("hold_back_run", 32'(state), 32'd0);
    step();
    chk("hold_once", 32'(bus.O_valid), 32'd0);

    // flush mid-MUL
    drive(4'd9, 32'd7, 32'd6, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    step(); idle();
    bus.I_flush = 1'b1;
    #1;
    chk("flush_aluop", 32'(alu_op), 32'd0);
    step();
    bus.I_flush = 1'b0;
    chk("flush_state", 32'(state), 32'd0);
    chk("flush_valid", 32'(bus.O_valid), 32'd0);
    chk("flush_stall", 32'(bus.O_stall), 32'd0);
    chk("flush_carry", 32'(bus.O_carry), 32'd1);
    drive(4'd0, 32'd1, 32'd1, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1);
    step(); idle();
    chk("flush_next_add", bus.O_result, 32'd2);
    chk("flush_next_valid", 32'(bus.O_valid), 32'd1);

    // reset mid-MUL
    drive(4'd9, 32'd7, 32'd6, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    step(); idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_carry = 1'b0; m_last = 32'd0;
    chk("rmul_state", 32'(state), 32'd0);
    chk("rmul_valid", 32'(bus.O_valid), 32'd0);
    chk("rmul_carry", 32'(bus.O_carry), 32'd0);
    chk("rmul_stall", 32'(bus.O_stall), 32'd0);
    drive(4'd0, 32'd1, 32'd1, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    step(); idle();
    chk("rmul_next_add", bus.O_result, 32'd2);

    // carry chain: set carry, ADD with Cin, XOR clears carry
    drive(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1);
    step();
    chk("cc_carry_set", 32'(bus.O_carry), 32'd1);
    drive(4'd0, 32'd1, 32'd1, 32'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    chk("cc_cin", 32'(alu_cin), 32'd1);
    step();
    chk("cc_add_cin", bus.O_result, 32'd3);
    drive(4'd3, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b1);
    step();
    chk("cc_xor_result", bus.O_result, 32'hFF00_FFFF);
    chk("cc_xor_carry", 32'(bus.O_carry), 32'd0);
    drive(4'd0, 32'd1, 32'd1, 32'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1);
    chk("cc_cin_clear", 32'(alu_cin), 32'd0);
    step(); idle();
    chk("cc_add_nocin", bus.O_result, 32'd2);

    // writeback forwarding, memStall hold, select 3 as register-file operand
    drive(4'd0, 32'h1234, 32'd23, 32'd100, 2'd2, 2'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1);
    step(); idle();
    chk("wb_result", bus.O_result, 32'd123);
    bus.I_memStall = 1'b1;
    bus.I_valid = 1'b1; bus.I_srcA = 32'd50; bus.I_srcB = 32'd7;
    #1;
    chk("ms_stall", 32'(bus.O_stall), 32'd1);
    step();
    chk("ms_result_held", bus.O_result, 32'd123);
    chk("ms_valid_held", 32'(bus.O_valid), 32'd1);
    bus.I_memStall = 1'b0;
    drive(4'd0, 32'd50, 32'd7, 32'd999, 2'd3, 2'd0, 1'b0, 1'b0, 5'd13, 1'b0, 1'b1);
    step(); idle();
    chk("fwd3_result", bus.O_result, 32'd57);
    step();
    chk("bubble_valid", 32'(bus.O_valid), 32'd0);

    step(); step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
